spi_follower_engine: RTL and testbench

Dedicated SPI follower (peripheral-side) engine that answers frames issued by the SPI leader on the shared cs/ext_clk/mosi lines. It oversamples the SPI lines in the system clock domain, shifts the received word in, shifts a preloaded word out on miso, and hands received words to the CPU side through a hold-until-acknowledged interface. It replaces the follower path of the combined leader/follower top so that follower-only builds do not carry leader logic.

---
 rtl/spi_follower_engine_if.sv | 21 ++
 rtl/spi_follower_engine.sv | 162 ++++++++++++++++
 tb/tb_spi_follower_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_follower_engine_if.sv
// CPU-side handshake bundle for spi_follower_engine: tx word hand-in and rx word hand-out.
interface spi_follower_engine_if #(
  parameter int MAX_W = 16
);
  logic [MAX_W-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [MAX_W-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ack;

  modport master (
    output tx_data, tx_valid, rx_ack,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ack,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_follower_engine.sv
// SPI follower engine: oversamples cs/ext_clk/mosi in the clk domain, shifts rx in and tx out.
// Optional macro SPI_FOLLOWER_FRAME_ERR_EN adds a frame_err pulse on aborted frames.
module spi_follower_engine #(
  parameter int               MAX_W = 16,
  parameter logic [MAX_W-1:0] FILL  = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpol,
  input  logic cpha,
  input  logic len,
  input  logic cs,
  input  logic ext_clk,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic overrun,
  output logic busy,
  spi_follower_engine_if.slave host
`ifdef SPI_FOLLOWER_FRAME_ERR_EN
  ,
  output logic frame_err
`endif
);

  localparam int CW = $clog2(MAX_W + 1);
  localparam logic [CW-1:0] CNT_8 = CW'(8);
  localparam logic [CW-1:0] CNT_W = CW'(MAX_W);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t           state, state_nxt;
  logic             cs_p0, cs_p1, cs_p2;
  logic             sck_p0, sck_p1, sck_p2;
  logic             mosi_p0, mosi_p1;
  logic             cpol_r, cpha_r, len_r;
  logic             skip;
  logic [MAX_W-1:0] tx_sh, rx_sh, rx_data_r;
  logic [CW-1:0]    cnt, cnt_inc, target;
  logic             rx_valid_r, overrun_r, tx_ready_r;
  logic             cs_fall, sck_lead, sck_trail, smp_edge, sft_edge, capture;

  // Synchronizer outputs: p1 is the usable level, p2 is the previous level for edge detection
  assign cs_fall   = cs_p2 & ~cs_p1;
  assign sck_lead  = (sck_p1 != cpol_r) && (sck_p2 == cpol_r);
  assign sck_trail = (sck_p1 == cpol_r) && (sck_p2 != cpol_r);
  assign smp_edge  = cpha_r ? sck_trail : sck_lead;
  assign sft_edge  = cpha_r ? sck_lead : sck_trail;
  assign cnt_inc   = cnt + 1'b1;
  assign target    = len_r ? CNT_W : CNT_8;
  assign capture   = (state == DONE) && (cnt != '0);

  assign miso_oe       = (state != IDLE) && !cs_p1;
  assign miso          = miso_oe & (len_r ? tx_sh[MAX_W-1] : tx_sh[7]);
  assign busy          = (state != IDLE);
  assign overrun       = overrun_r;
  assign host.rx_data  = rx_data_r;
  assign host.rx_valid = rx_valid_r;
  assign host.tx_ready = tx_ready_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_p1) state_nxt = IDLE;
               else if (smp_edge && (cnt_inc == target)) state_nxt = DONE;
      DONE:    if (cs_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0..p2: input synchronizers and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      sck_p0  <= 1'b0;
      sck_p1  <= 1'b0;
      sck_p2  <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      cs_p0   <= cs;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      sck_p0  <= ext_clk;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      mosi_p0 <= mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      len_r      <= 1'b0;
      skip       <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      cnt        <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      tx_ready_r <= 1'b0;
    end else begin
      tx_ready_r <= (state_nxt == IDLE);
      unique case (state)
        IDLE: if (cs_fall) begin
          cpol_r <= cpol;
          cpha_r <= cpha;
          len_r  <= len;
          tx_sh  <= (host.tx_valid && tx_ready_r) ? host.tx_data : FILL;
          rx_sh  <= '0;
          cnt    <= '0;
          skip   <= 1'b1;
        end
        ACTIVE: if (!cs_p1) begin
          if (smp_edge) begin
            rx_sh <= {rx_sh[MAX_W-2:0], mosi_p1};
            cnt   <= cnt_inc;
          end
          // In cpha=1 the MSB is already on miso, so the first leading edge must not shift
          if (sft_edge) begin
            if (cpha_r && skip) skip <= 1'b0;
            else                tx_sh <= {tx_sh[MAX_W-2:0], 1'b0};
          end
        end
        DONE: if (capture) begin
          rx_data_r <= rx_sh;
          cnt       <= '0;
        end
        default: ;
      endcase
      // A word landing in the same cycle as rx_ack wins and does not count as an overrun
      if (capture) begin
        rx_valid_r <= 1'b1;
        if (rx_valid_r && !host.rx_ack) overrun_r <= 1'b1;
      end else if (host.rx_ack) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

`ifdef SPI_FOLLOWER_FRAME_ERR_EN
  logic frame_err_r;
  assign frame_err = frame_err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_r <= 1'b0;
    else        frame_err_r <= (state == ACTIVE) && cs_p1 && (cnt != '0);
  end
`endif

endmodule

// File: tb/tb_spi_follower_engine.sv
// Bench for spi_follower_engine: directed frames from the spec plus randomized frames vs a word-level model.
module tb_spi_follower_engine;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, len = 1'b0;
  logic cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic miso, miso_oe, overrun, busy;
  logic frame_err;
  int   fe_cnt = 0;

  int checks = 0;
  int failures = 0;

  logic mid_oe, mid_busy, mid_rdy;
  logic [15:0] din;

  logic        m_valid, m_ovr;
  logic [15:0] m_data;

  spi_follower_engine_if #(.MAX_W(16)) bus ();

  spi_follower_engine #(.MAX_W(16), .FILL(16'h0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpol     (cpol),
    .cpha     (cpha),
    .len      (len),
    .cs       (cs),
    .ext_clk  (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .overrun  (overrun),
    .busy     (busy),
    .host     (bus.slave)
`ifdef SPI_FOLLOWER_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

`ifndef SPI_FOLLOWER_FRAME_ERR_EN
  assign frame_err = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) fe_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leader-side model of one frame; stops after stop_bits complete bits
  task automatic xfer(input bit pol, input bit pha, input bit ln, input logic [15:0] dout,
                      input int stop_bits, input bit raise_cs, output logic [15:0] rd);
    int nb;
    nb = ln ? 16 : 8;
    rd = '0;
    cpol = pol; cpha = pha; len = ln; sclk = pol;
    mosi = pha ? 1'b0 : dout[nb-1];
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    mid_oe = miso_oe; mid_busy = busy; mid_rdy = bus.tx_ready;
    for (int i = 0; i < nb && i < stop_bits; i++) begin
      sclk = ~pol;
      if (pha) mosi = dout[nb-1-i];
      else     rd = {rd[14:0], miso};
      repeat (HALF) @(negedge clk);
      sclk = pol;
      if (pha)            rd = {rd[14:0], miso};
      else if (i + 1 < nb) mosi = dout[nb-2-i];
      repeat (HALF) @(negedge clk);
    end
    if (raise_cs) begin
      cs = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic model_frame(input logic [15:0] w);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = w;
  endtask

  task automatic ack_and_check(input string tag);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    m_valid = 1'b0;
    chk({tag, "_ack_valid"}, {31'd0, bus.rx_valid}, {31'd0, m_valid});
    chk({tag, "_ack_ovr"}, {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  task automatic host_check(input string tag);
    chk({tag, "_rxdata"}, {16'd0, bus.rx_data}, {16'd0, m_data});
    chk({tag, "_rxvalid"}, {31'd0, bus.rx_valid}, {31'd0, m_valid});
    chk({tag, "_ovr"}, {31'd0, overrun}, {31'd0, m_ovr});
    chk({tag, "_idle_oe"}, {31'd0, miso_oe}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Full frame with word-level expectations: rx = leader word, leader sees loaded tx or FILL
  task automatic full_frame(input string tag, input bit pol, input bit pha, input bit ln,
                            input logic [15:0] send, input bit tv, input logic [15:0] txw);
    logic [15:0] mask, rd;
    mask = ln ? 16'hFFFF : 16'h00FF;
    bus.tx_data = txw; bus.tx_valid = tv;
    xfer(pol, pha, ln, send, 99, 1'b1, rd);
    bus.tx_valid = 1'b0;
    model_frame(send & mask);
    chk({tag, "_leader_rx"}, {16'd0, rd & mask}, {16'd0, tv ? (txw & mask) : 16'h0000});
    chk({tag, "_mid_oe"}, {31'd0, mid_oe}, 32'd1);
    chk({tag, "_mid_busy"}, {31'd0, mid_busy}, 32'd1);
    chk({tag, "_mid_rdy"}, {31'd0, mid_rdy}, 32'd0);
    host_check(tag);
  endtask

  initial begin
    int fe0;
    logic [15:0] rd;
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ack = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_rdy", {31'd0, bus.tx_ready}, 32'd0);
    chk("rst_rxvalid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_rxdata", {16'd0, bus.rx_data}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy", {31'd0, bus.tx_ready}, 32'd1);

    full_frame("m0_a5", 1'b0, 1'b0, 1'b0, 16'h00A5, 1'b1, 16'h003C);
    ack_and_check("m0_a5");
    full_frame("m3_6a", 1'b1, 1'b1, 1'b0, 16'h006A, 1'b1, 16'h000F);
    ack_and_check("m3_6a");
    full_frame("w16", 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'hBEEF);
    ack_and_check("w16");
    full_frame("fill", 1'b0, 1'b0, 1'b1, 16'h8001, 1'b0, 16'hFFFF);
    ack_and_check("fill");

    // Two frames without acknowledge
    full_frame("ov11", 1'b0, 1'b0, 1'b0, 16'h0011, 1'b1, 16'h0055);
    full_frame("ov22", 1'b0, 1'b0, 1'b0, 16'h0022, 1'b1, 16'h00AA);
    ack_and_check("ov22");

    // Abort after 3 bits while a previous word is still pending
    full_frame("pre_ab", 1'b0, 1'b1, 1'b0, 16'h005A, 1'b1, 16'h0081);
    fe0 = fe_cnt;
    bus.tx_data = 16'h00C3; bus.tx_valid = 1'b1;
    xfer(1'b0, 1'b0, 1'b0, 16'h00E7, 3, 1'b1, rd);
    bus.tx_valid = 1'b0;
    host_check("abort");
    chk("abort_rdy", {31'd0, bus.tx_ready}, 32'd1);
`ifdef SPI_FOLLOWER_FRAME_ERR_EN
    chk("abort_ferr", fe_cnt - fe0, 32'd1);
`else
    chk("abort_ferr", fe_cnt - fe0, 32'd0);
`endif

    // Reset in the middle of a frame, then a clean frame
    xfer(1'b0, 1'b0, 1'b0, 16'h00A5, 4, 1'b0, rd);
    rst_n = 1'b0;
    #1;
    chk("mrst_miso", {31'd0, miso}, 32'd0);
    chk("mrst_oe", {31'd0, miso_oe}, 32'd0);
    chk("mrst_rdy", {31'd0, bus.tx_ready}, 32'd0);
    chk("mrst_rxvalid", {31'd0, bus.rx_valid}, 32'd0);
    chk("mrst_rxdata", {16'd0, bus.rx_data}, 32'd0);
    chk("mrst_ovr", {31'd0, overrun}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ferr", {31'd0, frame_err}, 32'd0);
    m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    full_frame("post_rst", 1'b0, 1'b0, 1'b0, 16'h00C3, 1'b1, 16'h0096);

    // Randomized frames against the word-level model
    for (int n = 0; n < 24; n++) begin
      bit pol, pha, ln, tv, ab;
      logic [15:0] w, t;
      int k;
      pol = 1'($urandom); pha = 1'($urandom); ln = 1'($urandom);
      tv = 1'($urandom); ab = ($urandom_range(0, 5) == 0);
      w = 16'($urandom); t = 16'($urandom);
      if (ab) begin
        k = $urandom_range(1, ln ? 15 : 7);
        fe0 = fe_cnt;
        bus.tx_data = t; bus.tx_valid = tv;
        xfer(pol, pha, ln, w, k, 1'b1, rd);
        bus.tx_valid = 1'b0;
        host_check($sformatf("rnd%0d_ab", n));
`ifdef SPI_FOLLOWER_FRAME_ERR_EN
        chk($sformatf("rnd%0d_ferr", n), fe_cnt - fe0, 32'd1);
`endif
      end else begin
        full_frame($sformatf("rnd%0d", n), pol, pha, ln, w, tv, t);
      end
      if ($urandom_range(0, 1) == 1) ack_and_check($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
